// File: rtl/intersection_scheduler_pkg.sv
// Shared encodings and default timing for the intersection scheduler.
// Phase codes are visible on the phase debug output, so their values are fixed.
package intersection_scheduler_pkg;

  typedef enum logic [2:0] {
    S_NS_G = 3'd0,
    S_NS_Y = 3'd1,
    S_CLR  = 3'd2,
    S_EW_G = 3'd3,
    S_EW_Y = 3'd4,
    S_WALK = 3'd5
  } state_e;

  localparam logic DIR_NS = 1'b0;
  localparam logic DIR_EW = 1'b1;

  localparam int DEF_CW        = 12;
  localparam int DEF_GREEN_MIN = 256;
  localparam int DEF_GREEN_MAX = 1024;
  localparam int DEF_YELLOW    = 512;
  localparam int DEF_ALL_RED   = 128;
  localparam int DEF_WALK      = 512;

endpackage

// File: rtl/intersection_scheduler_if.sv
// Sensor inputs and lamp outputs of the intersection scheduler.
// No handshake: requests are levels (ped_req a latched pulse); lamps are Moore outputs.
interface intersection_scheduler_if;
  logic       req_ns;
  logic       req_ew;
  logic       ped_req;
  logic       ns_r;
  logic       ns_g;
  logic       ns_y;
  logic       ew_r;
  logic       ew_g;
  logic       ew_y;
  logic       walk;
  logic       ped_wait;
  logic [2:0] phase;

  modport master (
    output req_ns, req_ew, ped_req,
    input  ns_r, ns_g, ns_y, ew_r, ew_g, ew_y, walk, ped_wait, phase
  );

  modport slave (
    input  req_ns, req_ew, ped_req,
    output ns_r, ns_g, ns_y, ew_r, ew_g, ew_y, walk, ped_wait, phase
  );
endinterface

// File: rtl/intersection_scheduler_phase_timer.sv
// Per-phase cycle counter: restarts at 1 on a phase change and can be told
// to stop at MAX so a long green never wraps.
module intersection_scheduler_phase_timer #(
  parameter int CW  = 12,
  parameter int MAX = 1024
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_i,
  input  logic          sat_i,
  output logic [CW-1:0] cnt_o
);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (load_i) begin
      cnt_d = CW'(1);
    end else if (sat_i && (cnt_q >= CW'(MAX))) begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= CW'(1);
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/intersection_scheduler.sv
// Right-of-way sequencer for a two-road intersection with a pedestrian phase.
// Every change of right-of-way passes through yellow (vehicles) and all-red clearance.
module intersection_scheduler
  import intersection_scheduler_pkg::*;
#(
  parameter int CW        = DEF_CW,
  parameter int GREEN_MIN = DEF_GREEN_MIN,
  parameter int GREEN_MAX = DEF_GREEN_MAX,
  parameter int YELLOW    = DEF_YELLOW,
  parameter int ALL_RED   = DEF_ALL_RED,
  parameter int WALK      = DEF_WALK
) (
  input  logic                      clk,
  input  logic                      rst,
  intersection_scheduler_if.slave   bus
);

  state_e        state_q, state_d;
  logic          last_dir_q, last_dir_d;
  logic          ped_pending_q, ped_pending_d;
  logic          from_walk_q, from_walk_d;
  logic [CW-1:0] cnt;
  logic          state_chg;
  logic          in_green;
  logic          comp;
  logic          opp_req;
  logic          same_req;

  assign state_chg = (state_d != state_q);
  assign in_green  = (state_q == S_NS_G) || (state_q == S_EW_G);
  assign comp      = ((state_q == S_EW_G) ? bus.req_ns : bus.req_ew) | ped_pending_q;
  assign opp_req   = (last_dir_q == DIR_NS) ? bus.req_ew : bus.req_ns;
  assign same_req  = (last_dir_q == DIR_NS) ? bus.req_ns : bus.req_ew;

  intersection_scheduler_phase_timer #(
    .CW  (CW),
    .MAX (GREEN_MAX)
  ) u_phase_timer (
    .clk    (clk),
    .rst    (rst),
    .load_i (state_chg),
    .sat_i  (in_green),
    .cnt_o  (cnt)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_NS_G: if (comp && (cnt >= CW'(GREEN_MIN))) state_d = S_NS_Y;
      S_EW_G: if (comp && (cnt >= CW'(GREEN_MIN))) state_d = S_EW_Y;
      S_NS_Y: if (cnt == CW'(YELLOW)) state_d = S_CLR;
      S_EW_Y: if (cnt == CW'(YELLOW)) state_d = S_CLR;
      S_WALK: if (cnt == CW'(WALK)) state_d = S_CLR;
      S_CLR: begin
        if (cnt == CW'(ALL_RED)) begin
          // A walk never follows a walk; otherwise prefer the road that just waited.
          if (ped_pending_q && !from_walk_q) begin
            state_d = S_WALK;
          end else if (opp_req) begin
            state_d = (last_dir_q == DIR_NS) ? S_EW_G : S_NS_G;
          end else if (same_req) begin
            state_d = (last_dir_q == DIR_NS) ? S_NS_G : S_EW_G;
          end else begin
            state_d = S_NS_G;
          end
        end
      end
      default: state_d = S_CLR;
    endcase
  end

  always_comb begin
    last_dir_d = last_dir_q;
    if (state_chg && (state_d == S_NS_G)) last_dir_d = DIR_NS;
    if (state_chg && (state_d == S_EW_G)) last_dir_d = DIR_EW;

    from_walk_d = state_chg ? (state_q == S_WALK) : from_walk_q;

    ped_pending_d = ped_pending_q;
    if (state_chg && (state_d == S_WALK)) begin
      ped_pending_d = 1'b0;
    end else if (bus.ped_req && (state_q != S_WALK)) begin
      ped_pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_NS_G;
      last_dir_q    <= DIR_NS;
      ped_pending_q <= 1'b0;
      from_walk_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_dir_q    <= last_dir_d;
      ped_pending_q <= ped_pending_d;
      from_walk_q   <= from_walk_d;
    end
  end

  logic ns_r, ns_g, ns_y, ew_r, ew_g, ew_y, walk;

  always_comb begin
    ns_r = 1'b0;
    ns_g = 1'b0;
    ns_y = 1'b0;
    ew_r = 1'b0;
    ew_g = 1'b0;
    ew_y = 1'b0;
    walk = 1'b0;
    case (state_q)
      S_NS_G: begin ns_g = 1'b1; ew_r = 1'b1; end
      S_NS_Y: begin ns_y = 1'b1; ew_r = 1'b1; end
      S_EW_G: begin ew_g = 1'b1; ns_r = 1'b1; end
      S_EW_Y: begin ew_y = 1'b1; ns_r = 1'b1; end
      S_CLR:  begin ns_r = 1'b1; ew_r = 1'b1; end
      S_WALK: begin ns_r = 1'b1; ew_r = 1'b1; walk = 1'b1; end
      default: ;
    endcase
  end

  assign bus.ns_r     = ns_r;
  assign bus.ns_g     = ns_g;
  assign bus.ns_y     = ns_y;
  assign bus.ew_r     = ew_r;
  assign bus.ew_g     = ew_g;
  assign bus.ew_y     = ew_y;
  assign bus.walk     = walk;
  assign bus.ped_wait = ped_pending_q;
  assign bus.phase    = state_q;

endmodule

// File: tb/tb_intersection_scheduler.sv
// Bench for intersection_scheduler: expected phase/dwell pairs are queued and
// matched against the observed phase sequence, plus lamp safety monitoring.
module tb_intersection_scheduler;
  import intersection_scheduler_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  logic [14:0] exp_q[$];

  intersection_scheduler_if bus();

  intersection_scheduler dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] lamps_for(input logic [2:0] ph);
    case (ph)
      3'd0:    return 7'b0101000;
      3'd1:    return 7'b0011000;
      3'd2:    return 7'b1001000;
      3'd3:    return 7'b1000100;
      3'd4:    return 7'b1000010;
      3'd5:    return 7'b1001001;
      default: return 7'b0000000;
    endcase
  endfunction

  function automatic logic [6:0] lamps_now();
    return {bus.ns_r, bus.ns_g, bus.ns_y, bus.ew_r, bus.ew_g, bus.ew_y, bus.walk};
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      if (((bus.ns_g | bus.ns_y) & (bus.ew_g | bus.ew_y)) === 1'b1 ||
          (bus.walk === 1'b1 && !(bus.ns_r === 1'b1 && bus.ew_r === 1'b1))) begin
        failures++;
        $display("FAIL lamp_safety t=%0t lamps=%b", $time, lamps_now());
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    bus.req_ns = 1'b0;
    bus.req_ew = 1'b0;
    bus.ped_req = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  // Pops {phase, dwell}; dwell 0 means only check that the phase has been entered.
  task automatic check_seq(input string tag);
    logic [14:0] e;
    logic [2:0]  ph;
    int          n;
    while (exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      ph = e[14:12];
      checks++;
      if (bus.phase !== ph) begin
        failures++;
        $display("FAIL %s_phase got=%0d exp=%0d t=%0t", tag, bus.phase, ph, $time);
      end
      checks++;
      if (lamps_now() !== lamps_for(ph)) begin
        failures++;
        $display("FAIL %s_lamps ph=%0d got=%b exp=%b", tag, ph, lamps_now(), lamps_for(ph));
      end
      if (e[11:0] != 12'd0) begin
        n = 0;
        while (bus.phase === ph && n < 3000) begin
          n++;
          @(negedge clk);
        end
        checks++;
        if (n != int'(e[11:0])) begin
          failures++;
          $display("FAIL %s_dwell ph=%0d got=%0d exp=%0d", tag, ph, n, e[11:0]);
        end
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    bus.ped_req = 1'b1;
    @(negedge clk);
    checks++;
    if (lamps_now() !== 7'b0101000) begin
      failures++;
      $display("FAIL reset_lamps got=%b exp=%b", lamps_now(), 7'b0101000);
    end
    checks++;
    if (bus.phase !== 3'd0 || bus.ped_wait !== 1'b0) begin
      failures++;
      $display("FAIL reset_phase_wait got=%0d/%b exp=0/0", bus.phase, bus.ped_wait);
    end
    checks++;
    if (dut.cnt !== 12'd1) begin
      failures++;
      $display("FAIL reset_cnt got=%0d exp=1", dut.cnt);
    end
    bus.ped_req = 1'b0;
  endtask

  task automatic test_ew_request();
    do_reset();
    bus.req_ew = 1'b1;
    rst = 1'b0;
    exp_q.push_back({S_NS_G, 12'd256});
    exp_q.push_back({S_NS_Y, 12'd512});
    exp_q.push_back({S_CLR,  12'd128});
    exp_q.push_back({S_EW_G, 12'd0});
    check_seq("ew_req");
    checks++;
    if (dut.last_dir_q !== 1'b1) begin
      failures++;
      $display("FAIL ew_last_dir got=%b exp=1", dut.last_dir_q);
    end
  endtask

  task automatic test_idle();
    int bad = 0;
    do_reset();
    rst = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      if (bus.ns_g !== 1'b1 || bus.phase !== 3'd0) bad++;
      @(negedge clk);
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL idle_hold bad_cycles=%0d exp=0", bad);
    end
    checks++;
    if (dut.cnt !== 12'd1024) begin
      failures++;
      $display("FAIL idle_cnt_sat got=%0d exp=1024", dut.cnt);
    end
  endtask

  task automatic test_ped();
    do_reset();
    bus.req_ns = 1'b1;
    rst = 1'b0;
    repeat (10) @(negedge clk);
    bus.ped_req = 1'b1;
    @(negedge clk);
    bus.ped_req = 1'b0;
    checks++;
    if (bus.ped_wait !== 1'b1) begin
      failures++;
      $display("FAIL ped_wait_set got=%b exp=1", bus.ped_wait);
    end
    exp_q.push_back({S_NS_G, 12'd245});
    exp_q.push_back({S_NS_Y, 12'd512});
    exp_q.push_back({S_CLR,  12'd128});
    exp_q.push_back({S_WALK, 12'd0});
    check_seq("ped");
    checks++;
    if (bus.ped_wait !== 1'b0 || bus.walk !== 1'b1) begin
      failures++;
      $display("FAIL ped_walk_entry wait=%b walk=%b exp=0/1", bus.ped_wait, bus.walk);
    end
    repeat (100) @(negedge clk);
    bus.ped_req = 1'b1;
    @(negedge clk);
    bus.ped_req = 1'b0;
    checks++;
    if (bus.ped_wait !== 1'b0) begin
      failures++;
      $display("FAIL ped_ignored_in_walk got=%b exp=0", bus.ped_wait);
    end
    exp_q.push_back({S_WALK, 12'd411});
    exp_q.push_back({S_CLR,  12'd128});
    exp_q.push_back({S_NS_G, 12'd0});
    check_seq("ped_after");
  endtask

  task automatic test_short_pulse();
    int bad = 0;
    do_reset();
    bus.req_ew = 1'b1;
    rst = 1'b0;
    repeat (100) @(negedge clk);
    bus.req_ew = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (bus.ns_g !== 1'b1 || bus.phase !== 3'd0) bad++;
      @(negedge clk);
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL short_pulse_hold bad_cycles=%0d exp=0", bad);
    end
  endtask

  task automatic test_ped_on_walk_entry();
    do_reset();
    rst = 1'b0;
    repeat (5) @(negedge clk);
    bus.ped_req = 1'b1;
    @(negedge clk);
    bus.ped_req = 1'b0;
    exp_q.push_back({S_NS_G, 12'd250});
    exp_q.push_back({S_NS_Y, 12'd512});
    exp_q.push_back({S_CLR,  12'd0});
    check_seq("pwe");
    repeat (127) @(negedge clk);
    bus.ped_req = 1'b1;
    @(negedge clk);
    bus.ped_req = 1'b0;
    checks++;
    if (bus.phase !== 3'd5 || bus.ped_wait !== 1'b0) begin
      failures++;
      $display("FAIL pwe_clear_wins phase=%0d wait=%b exp=5/0", bus.phase, bus.ped_wait);
    end
    bus.req_ew = 1'b1;
    exp_q.push_back({S_WALK, 12'd512});
    exp_q.push_back({S_CLR,  12'd128});
    exp_q.push_back({S_EW_G, 12'd0});
    check_seq("pwe_after");
  endtask

  task automatic test_mid_reset();
    do_reset();
    bus.req_ew = 1'b1;
    rst = 1'b0;
    exp_q.push_back({S_NS_G, 12'd256});
    exp_q.push_back({S_NS_Y, 12'd512});
    exp_q.push_back({S_CLR,  12'd128});
    exp_q.push_back({S_EW_G, 12'd0});
    check_seq("mr_pre");
    bus.req_ew = 1'b0;
    bus.req_ns = 1'b1;
    exp_q.push_back({S_EW_G, 12'd256});
    exp_q.push_back({S_EW_Y, 12'd0});
    check_seq("mr_ew");
    repeat (100) @(negedge clk);
    bus.req_ew = 1'b1;
    bus.req_ns = 1'b0;
    #3 rst = 1'b1;
    #1;
    checks++;
    if (lamps_now() !== 7'b0101000 || bus.phase !== 3'd0) begin
      failures++;
      $display("FAIL mr_async lamps=%b phase=%0d exp=0101000/0", lamps_now(), bus.phase);
    end
    @(negedge clk);
    checks++;
    if (dut.cnt !== 12'd1) begin
      failures++;
      $display("FAIL mr_cnt got=%0d exp=1", dut.cnt);
    end
    rst = 1'b0;
    exp_q.push_back({S_NS_G, 12'd256});
    exp_q.push_back({S_NS_Y, 12'd0});
    check_seq("mr_post");
  endtask

  initial begin
    bus.req_ns = 1'b0;
    bus.req_ew = 1'b0;
    bus.ped_req = 1'b0;
    test_reset();
    test_ew_request();
    test_idle();
    test_ped();
    test_short_pulse();
    test_ped_on_walk_entry();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
